// File: rtl/layer0_bias_relu_if.sv
// Handshake bundle for the layer-0 bias/ReLU stage: accumulator input, bias ROM port,
// activation output and pass status.
interface layer0_bias_relu_if;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned BIAS_W = 16;
  localparam int unsigned ACT_W  = 16;
  localparam int unsigned IDX_W  = 8;

  logic              start;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_data;
  logic [IDX_W-1:0]  bias_addr;
  logic [BIAS_W-1:0] bias_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACT_W-1:0]  out_data;
  logic [IDX_W-1:0]  out_index;
  logic              busy;
  logic              done;

  // Environment side: sequencer, MAC array, bias ROM and activation sink.
  modport master (
    output start, acc_valid, acc_data, bias_data, out_ready,
    input  acc_ready, bias_addr, out_valid, out_data, out_index, busy, done
  );

  // Bias/ReLU block side.
  modport slave (
    input  start, acc_valid, acc_data, bias_data, out_ready,
    output acc_ready, bias_addr, out_valid, out_data, out_index, busy, done
  );
endinterface

// File: rtl/layer0_bias_relu.sv
// Layer-0 bias add + ReLU: each Q16.16 MAC result gets its Q8.8 ROM bias added, is floored
// to Q8.8, clamped to [0, 0x7FFF] and presented through a one-deep output register.
module layer0_bias_relu #(
  parameter int unsigned NUM_NEURONS = 256
) (
  input  logic              clk,
  input  logic              rst,
  layer0_bias_relu_if.slave bus_if
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ACT_W = 16;
  localparam int unsigned SUM_W = 33;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [ACT_W-1:0]         out_data_q, out_data_d;
  logic [CNT_W-1:0]         out_index_q, out_index_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic                     acc_ready_c;
  logic                     acc_hs_c;
  logic                     out_hs_c;
  logic                     last_c;
  logic signed [SUM_W-1:0]  acc_ext_c;
  logic signed [SUM_W-1:0]  bias_ext_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [SUM_W-1:0]  q_c;
  logic [ACT_W-1:0]         act_c;

  // Accept only while the output register is empty or draining this cycle.
  assign acc_ready_c = (state_q == S_RUN) && (!out_valid_q || bus_if.out_ready);
  assign acc_hs_c    = bus_if.acc_valid && acc_ready_c;
  assign out_hs_c    = out_valid_q && bus_if.out_ready;
  assign last_c      = (cnt_q == CNT_LAST);

  // Bias is aligned to Q16.16 by <<8; the >>>8 back to Q8.8 floors toward -inf.
  assign acc_ext_c  = $signed({bus_if.acc_data[31], bus_if.acc_data});
  assign bias_ext_c = $signed({{9{bus_if.bias_data[15]}}, bus_if.bias_data, 8'h00});
  assign sum_c      = acc_ext_c + bias_ext_c;
  assign q_c        = sum_c >>> 8;

  always_comb begin
    act_c = q_c[ACT_W-1:0];
    if (q_c < 33'sd0) begin
      act_c = '0;
    end else if (q_c > 33'sd32767) begin
      act_c = 16'h7FFF;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus_if.start) state_d = S_RUN;
      S_RUN:   if (acc_hs_c && last_c) state_d = S_FLUSH;
      S_FLUSH: if (!out_valid_q || bus_if.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    done_d      = 1'b0;
    busy_d      = (state_d != S_IDLE);

    if ((state_q == S_IDLE) && bus_if.start) begin
      cnt_d = '0;
    end

    // A consume and an accept in the same cycle reload the register without a bubble.
    if (acc_hs_c) begin
      out_valid_d = 1'b1;
      out_data_d  = act_c;
      out_index_d = cnt_q;
      if (!last_c) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (out_hs_c) begin
      out_valid_d = 1'b0;
    end

    if ((state_q == S_FLUSH) && (state_d == S_IDLE)) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus_if.acc_ready = acc_ready_c;
  assign bus_if.bias_addr = cnt_q;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_data  = out_data_q;
  assign bus_if.out_index = out_index_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.done      = done_q;
endmodule

// File: tb/tb_layer0_bias_relu.sv
// Directed bench for layer0_bias_relu: value/clamp vectors, backpressure, a full 256-neuron
// pass with random gaps, mid-pass reset and a single-neuron configuration.
module tb_layer0_bias_relu;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  layer0_bias_relu_if bif ();
  layer0_bias_relu_if bif1 ();

  layer0_bias_relu #(.NUM_NEURONS(256)) dut  (.clk(clk), .rst(rst), .bus_if(bif));
  layer0_bias_relu #(.NUM_NEURONS(1))   dut1 (.clk(clk), .rst(rst), .bus_if(bif1));

  logic [15:0] bias_mem [256];
  assign bif.bias_data  = bias_mem[bif.bias_addr];
  assign bif1.bias_data = 16'h0100;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.start      = 1'b0;
    bif.acc_valid  = 1'b0;
    bif.acc_data   = '0;
    bif.out_ready  = 1'b0;
    bif1.start     = 1'b0;
    bif1.acc_valid = 1'b0;
    bif1.acc_data  = '0;
    bif1.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_pass();
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bif.out_valid); end
    checks++; if (bif.out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data: got %h want 0000", bif.out_data); end
    checks++; if (bif.out_index !== 8'h00) begin failures++; $display("FAIL reset_out_index: got %h want 00", bif.out_index); end
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
    checks++; if (bif.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bif.done); end
    checks++; if (bif.bias_addr !== 8'h00) begin failures++; $display("FAIL reset_bias_addr: got %h want 00", bif.bias_addr); end
    rst = 1'b0;
    bif.acc_valid = 1'b1;
    bif.out_ready = 1'b1;
    tick();
    tick();
    checks++; if (bif.acc_ready !== 1'b0) begin failures++; $display("FAIL idle_acc_ready: got %b want 0", bif.acc_ready); end
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL idle_no_output: got %b want 0", bif.out_valid); end
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", bif.busy); end
    idle_inputs();
  endtask

  task automatic test_values();
    logic [31:0] acc_v [6];
    logic [15:0] exp_v [6];
    acc_v = '{32'h00010000, 32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h00790000, 32'h00007A00};
    exp_v = '{16'h0087,     16'h0000,     16'h7FFF,     16'h0000,     16'h7887,     16'h0001};
    for (int a = 0; a < 256; a++) bias_mem[a] = 16'hFF87;
    do_reset();
    start_pass();
    checks++; if (bif.busy !== 1'b1) begin failures++; $display("FAIL run_busy: got %b want 1", bif.busy); end
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL run_no_early_valid: got %b want 0", bif.out_valid); end
    bif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bif.acc_valid = 1'b1;
      bif.acc_data  = acc_v[i];
      #1;
      checks++; if (bif.acc_ready !== 1'b1) begin failures++; $display("FAIL val_acc_ready[%0d]: got %b want 1", i, bif.acc_ready); end
      checks++; if (bif.bias_addr !== 8'(i)) begin failures++; $display("FAIL val_bias_addr[%0d]: got %0d want %0d", i, bif.bias_addr, i); end
      tick();
      checks++; if (bif.out_valid !== 1'b1) begin failures++; $display("FAIL val_latency[%0d]: got %b want 1", i, bif.out_valid); end
      checks++; if (bif.out_index !== 8'(i)) begin failures++; $display("FAIL val_index[%0d]: got %0d want %0d", i, bif.out_index, i); end
      checks++; if (bif.out_data !== exp_v[i]) begin failures++; $display("FAIL val_data[%0d]: got %h want %h", i, bif.out_data, exp_v[i]); end
    end
    bif.acc_valid = 1'b0;
    tick();
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL val_drain: got %b want 0", bif.out_valid); end
    do_reset();
  endtask

  task automatic test_backpressure();
    for (int a = 0; a < 256; a++) bias_mem[a] = 16'(a);
    do_reset();
    start_pass();
    bif.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bif.acc_valid = 1'b1;
      bif.acc_data  = 32'(k) << 8;
      tick();
    end
    checks++; if (bif.out_index !== 8'd1) begin failures++; $display("FAIL bp_pre_index: got %0d want 1", bif.out_index); end
    bif.out_ready = 1'b0;
    bif.acc_data  = 32'(2) << 8;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bif.acc_ready !== 1'b0) begin failures++; $display("FAIL bp_acc_ready[%0d]: got %b want 0", c, bif.acc_ready); end
      tick();
      checks++; if ({bif.out_valid, bif.out_index, bif.out_data} !== {1'b1, 8'd1, 16'd2}) begin
        failures++; $display("FAIL bp_hold[%0d]: got v=%b i=%0d d=%h want v=1 i=1 d=0002", c, bif.out_valid, bif.out_index, bif.out_data);
      end
    end
    bif.out_ready = 1'b1;
    for (int k = 2; k < 6; k++) begin
      bif.acc_data = 32'(k) << 8;
      #1;
      checks++; if (bif.acc_ready !== 1'b1) begin failures++; $display("FAIL bp_resume_ready[%0d]: got %b want 1", k, bif.acc_ready); end
      tick();
      checks++; if ({bif.out_valid, bif.out_index, bif.out_data} !== {1'b1, 8'(k), 16'(2 * k)}) begin
        failures++; $display("FAIL bp_resume[%0d]: got v=%b i=%0d d=%h want v=1 i=%0d d=%h", k, bif.out_valid, bif.out_index, bif.out_data, k, 16'(2 * k));
      end
    end
    bif.acc_valid = 1'b0;
    tick();
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b want 0", bif.out_valid); end
    do_reset();
  endtask

  task automatic test_full_pass();
    int next_acc = 0;
    int next_out = 0;
    int done_cnt = 0;
    int last_out = -10;
    int done_cyc = -1;
    int cyc      = 0;
    for (int a = 0; a < 256; a++) bias_mem[a] = 16'(a);
    do_reset();
    start_pass();
    checks++; if (bif.busy !== 1'b1) begin failures++; $display("FAIL full_busy: got %b want 1", bif.busy); end
    while (cyc < 5000 && !(done_cnt > 0 && cyc > done_cyc + 5)) begin
      bif.acc_valid = (next_acc < 256) && ($urandom_range(0, 3) != 0);
      bif.acc_data  = 32'(next_acc) << 8;
      bif.out_ready = ($urandom_range(0, 3) != 0);
      bif.start     = (cyc == 50);
      #1;
      if (bif.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        checks++; if (cyc != last_out + 1) begin failures++; $display("FAIL full_done_timing: got cycle %0d want %0d", cyc, last_out + 1); end
      end
      if (bif.acc_valid && bif.acc_ready) begin
        checks++; if (bif.bias_addr !== 8'(next_acc)) begin failures++; $display("FAIL full_bias_addr: got %0d want %0d", bif.bias_addr, next_acc); end
        next_acc++;
      end
      if (bif.out_valid && bif.out_ready) begin
        checks++; if (bif.out_index !== 8'(next_out)) begin failures++; $display("FAIL full_index: got %0d want %0d", bif.out_index, next_out); end
        checks++; if (bif.out_data !== 16'(2 * next_out)) begin failures++; $display("FAIL full_data: got %h want %h", bif.out_data, 16'(2 * next_out)); end
        next_out++;
        last_out = cyc;
      end
      tick();
      cyc++;
    end
    idle_inputs();
    checks++; if (next_out != 256) begin failures++; $display("FAIL full_out_count: got %0d want 256", next_out); end
    checks++; if (next_acc != 256) begin failures++; $display("FAIL full_acc_count: got %0d want 256", next_acc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL full_end_busy: got %b want 0", bif.busy); end
    do_reset();
  endtask

  task automatic test_reset_mid_pass();
    int done_seen = 0;
    for (int a = 0; a < 256; a++) bias_mem[a] = 16'(a);
    do_reset();
    start_pass();
    bif.out_ready = 1'b1;
    bif.acc_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bif.acc_data = 32'(k) << 8;
      tick();
    end
    checks++; if (bif.bias_addr !== 8'd100) begin failures++; $display("FAIL mid_cnt: got %0d want 100", bif.bias_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid: got %b want 0", bif.out_valid); end
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL mid_async_busy: got %b want 0", bif.busy); end
    checks++; if (bif.bias_addr !== 8'd0) begin failures++; $display("FAIL mid_async_cnt: got %0d want 0", bif.bias_addr); end
    checks++; if (bif.acc_ready !== 1'b0) begin failures++; $display("FAIL mid_async_ready: got %b want 0", bif.acc_ready); end
    idle_inputs();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bif.done !== 1'b0) done_seen++;
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL mid_no_done: got %0d pulses want 0", done_seen); end
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL mid_wait_idle: got %b want 0", bif.busy); end
    start_pass();
    bif.out_ready = 1'b1;
    bif.acc_valid = 1'b1;
    bif.acc_data  = 32'h00000300;
    #1;
    checks++; if (bif.bias_addr !== 8'd0) begin failures++; $display("FAIL mid_restart_addr: got %0d want 0", bif.bias_addr); end
    tick();
    checks++; if ({bif.out_valid, bif.out_index, bif.out_data} !== {1'b1, 8'd0, 16'h0003}) begin
      failures++; $display("FAIL mid_restart_out: got v=%b i=%0d d=%h want v=1 i=0 d=0003", bif.out_valid, bif.out_index, bif.out_data);
    end
    do_reset();
  endtask

  task automatic test_single_neuron();
    do_reset();
    bif1.start = 1'b1;
    tick();
    bif1.start     = 1'b0;
    bif1.acc_valid = 1'b1;
    bif1.acc_data  = 32'h00020000;
    bif1.out_ready = 1'b1;
    #1;
    checks++; if (bif1.acc_ready !== 1'b1) begin failures++; $display("FAIL one_acc_ready: got %b want 1", bif1.acc_ready); end
    tick();
    checks++; if (bif1.acc_ready !== 1'b0) begin failures++; $display("FAIL one_flush_ready: got %b want 0", bif1.acc_ready); end
    checks++; if ({bif1.out_valid, bif1.out_index, bif1.out_data} !== {1'b1, 8'd0, 16'h0300}) begin
      failures++; $display("FAIL one_out: got v=%b i=%0d d=%h want v=1 i=0 d=0300", bif1.out_valid, bif1.out_index, bif1.out_data);
    end
    checks++; if (bif1.busy !== 1'b1) begin failures++; $display("FAIL one_flush_busy: got %b want 1", bif1.busy); end
    tick();
    checks++; if ({bif1.done, bif1.busy, bif1.out_valid} !== 3'b100) begin
      failures++; $display("FAIL one_done: got done=%b busy=%b v=%b want 1 0 0", bif1.done, bif1.busy, bif1.out_valid);
    end
    bif1.acc_valid = 1'b0;
    tick();
    checks++; if (bif1.done !== 1'b0) begin failures++; $display("FAIL one_done_width: got %b want 0", bif1.done); end
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    for (int a = 0; a < 256; a++) bias_mem[a] = '0;
    test_reset();
    test_values();
    test_backpressure();
    test_full_pass();
    test_reset_mid_pass();
    test_single_neuron();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/layer0_bias_relu.md
LAYER0_BIAS_RELU -- requirements
Module: layer0_bias_relu

Interface
REQ-001 Parameter NUM_NEURONS, default 256, is the number of neurons per layer pass (legal range 1..256).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse that begins a layer pass; honoured only in IDLE.
REQ-005 acc_valid  input  1  upstream MAC accumulator result is valid.
REQ-006 acc_ready  output  1  block accepts acc_data this cycle.
REQ-007 acc_data  input  32  signed Q16.16 dot-product for the current neuron.
REQ-008 bias_addr  output  8  address to the combinational Q8.8 bias ROM.
REQ-009 bias_data  input  16  signed Q8.8 bias returned by the ROM in the same cycle.
REQ-010 out_valid  output  1  activation output is valid.
REQ-011 out_ready  input  1  downstream accepts the output.
REQ-012 out_data  output  16  signed Q8.8 activation, always >= 0.
REQ-013 out_index  output  8  neuron index of out_data.
REQ-014 busy  output  1  high in RUN or FLUSH.
REQ-015 done  output  1  one-cycle pulse at the end of a pass.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and FLUSH.
REQ-017 IDLE transitions to RUN on start=1; start is ignored in RUN and FLUSH.
REQ-018 Neuron counter cnt (8 bits) SHALL be cleared to 0 on entry to RUN and shall drive bias_addr combinationally.
REQ-019 acc_ready = (state==RUN) && (!out_valid || out_ready); acc_ready is 0 in IDLE and FLUSH.
REQ-020 An acc handshake (acc_valid && acc_ready) SHALL compute sum33 = sext(acc_data) + (sext(bias_data) << 8) in 33-bit signed arithmetic.
REQ-021 The result SHALL be q = sum33 >>> 8 (arithmetic shift, truncation toward negative infinity).
REQ-022 ReLU and saturation: q<0 -> 16'h0000; q>32767 -> 16'h7FFF; otherwise q[15:0].
REQ-023 On a handshake, out_data and out_index (=cnt) SHALL be registered and out_valid shall be set on the next edge, giving a latency of 1 cycle.
REQ-024 cnt increments on each handshake; the handshake with cnt==NUM_NEURONS-1 moves RUN to FLUSH, and cnt is not advanced past NUM_NEURONS-1.
REQ-025 out_valid, out_data and out_index SHALL hold stable while out_valid && !out_ready.
REQ-026 out_valid clears on out_ready unless a new handshake occurs in the same cycle; a simultaneous consume and accept reloads the register without a bubble.
REQ-027 FLUSH waits until the last output has been consumed, then asserts done for exactly 1 cycle and returns to IDLE.
REQ-028 With NUM_NEURONS=1, RUN goes to FLUSH after a single handshake.

Reset
REQ-029 rst=1 SHALL force state=IDLE, cnt=0, out_valid=0, out_data=0, out_index=0, done=0 and busy=0 immediately, without waiting for a clock edge.
REQ-030 Reset during RUN or FLUSH abandons the pass; a pending output is discarded and no done pulse is produced.
REQ-031 After reset is released, the block waits in IDLE for a new start.

Verification
REQ-032 Positive path: acc_data=0x00010000, bias_data=0xFF87, out_ready=1 -> out_data=0x0087, out_index=0, out_valid 1 cycle after the handshake.
REQ-033 ReLU clamp: acc_data=0x00000000, bias_data=0xFF87 -> out_data=0x0000.
REQ-034 Saturation: acc_data=0x7FFFFFFF, bias_data=0xFF87 -> out_data=0x7FFF; acc_data=0x80000000 -> out_data=0x0000.
REQ-035 Backpressure: out_ready=0 for 5 cycles with acc_valid=1 -> acc_ready=0 and out_* held constant; out_ready=1 -> one transfer per cycle resumes with no lost or duplicated index.
REQ-036 Full pass: start, then 256 accumulators with random valid/ready gaps -> out_index sequence 0..255 and bias_addr matches cnt at each handshake; done pulses once, 1 cycle after the index-255 output is consumed; start during RUN is ignored.
REQ-037 Reset mid-pass: assert rst at cnt=100 -> out_valid=0 and busy=0 asynchronously; a new start restarts at index 0.
